// File: rtl/run_cmd_ctrl.sv
// run_cmd_ctrl: run-control sequencer between the monitor command decoder
// and cpu_status. Converts START/QUIT/STEP/BREAK commands into single-cycle
// cpu_start / quit_cmd pulses, tracks the resume PC, counts retired
// instructions for single-step, matches a hardware breakpoint, and holds a
// drain window after every quit so a new start never overlaps the pipeline
// reset propagation.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   cmd_valid/cmd_ready   command handshake (ready low only while draining)
//   cmd_code, cmd_data    0 START(pc), 1 QUIT, 2 STEP(count), 3 BREAK({pc[31:2],0,en})
//   cmd_err               1-cycle pulse: accepted command illegal in this state
//   pc_wb, pc_wb_valid    retiring instruction PC / strobe
//   cpu_start, quit_cmd   1-cycle pulses to cpu_status
//   start_pc              resume PC
//   run_state             0 IDLE, 1 RUN, 2 STEP, 3 DRAIN
//   brk_hit               sticky: last stop caused by the breakpoint
//   step_remain           remaining single-step count
module run_cmd_ctrl #(
    parameter int unsigned STEP_W    = 16,
    parameter int unsigned DRAIN_CYC = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_code,
    input  logic [31:0]       cmd_data,
    output logic              cmd_ready,
    output logic              cmd_err,
    input  logic [31:0]       pc_wb,
    input  logic              pc_wb_valid,
    output logic              cpu_start,
    output logic              quit_cmd,
    output logic [31:0]       start_pc,
    output logic [1:0]        run_state,
    output logic              brk_hit,
    output logic [STEP_W-1:0] step_remain
);

    localparam int unsigned CNT_W = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        CMD_START = 2'd0,
        CMD_QUIT  = 2'd1,
        CMD_STEP  = 2'd2,
        CMD_BREAK = 2'd3
    } cmd_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        start_pc_q, start_pc_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [31:0]        brk_pc_q, brk_pc_d;
    logic               brk_en_q, brk_en_d;
    logic               brk_hit_q, brk_hit_d;
    logic               cpu_start_q, cpu_start_d;
    logic               quit_q, quit_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic               cmd_acc;
    logic               brk_match;
    logic               step_last;
    logic               run_stop;
    logic [STEP_W-1:0]  step_n;

    // Event decode shared by the next-state logic.
    assign cmd_acc   = cmd_valid & (state_q != ST_DRAIN);
    assign brk_match = pc_wb_valid & brk_en_q & (pc_wb == brk_pc_q);
    assign step_last = (state_q == ST_STEP) & pc_wb_valid & (step_q == STEP_W'(1));
    assign run_stop  = brk_match | (cmd_acc & (cmd_code == CMD_QUIT)) | step_last;
    assign step_n    = cmd_data[STEP_W-1:0];

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            start_pc_q  <= '0;
            step_q      <= '0;
            brk_pc_q    <= '0;
            brk_en_q    <= 1'b0;
            brk_hit_q   <= 1'b0;
            cpu_start_q <= 1'b0;
            quit_q      <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_pc_q  <= start_pc_d;
            step_q      <= step_d;
            brk_pc_q    <= brk_pc_d;
            brk_en_q    <= brk_en_d;
            brk_hit_q   <= brk_hit_d;
            cpu_start_q <= cpu_start_d;
            quit_q      <= quit_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    // Next-state and pulse logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_pc_d  = start_pc_q;
        step_d      = step_q;
        brk_pc_d    = brk_pc_q;
        brk_en_d    = brk_en_q;
        brk_hit_d   = brk_hit_q;
        cpu_start_d = 1'b0;
        quit_d      = 1'b0;
        err_d       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    unique case (cmd_code)
                        CMD_START: begin
                            start_pc_d  = cmd_data;
                            cpu_start_d = 1'b1;
                            brk_hit_d   = 1'b0;
                            state_d     = ST_RUN;
                        end
                        CMD_STEP: begin
                            // start_pc kept: stepping resumes where the last stop left off.
                            if (step_n == '0) begin
                                err_d = 1'b1;
                            end else begin
                                step_d      = step_n;
                                brk_hit_d   = 1'b0;
                                cpu_start_d = 1'b1;
                                state_d     = ST_STEP;
                            end
                        end
                        CMD_QUIT:  err_d = 1'b1;
                        CMD_BREAK: ;
                        default:   ;
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                if (pc_wb_valid) begin
                    start_pc_d = pc_wb + 32'd4;
                    if ((state_q == ST_STEP) && (step_q != '0)) begin
                        step_d = step_q - STEP_W'(1);
                    end
                end
                if (cmd_acc && ((cmd_code == CMD_START) || (cmd_code == CMD_STEP))) begin
                    err_d = 1'b1;
                end
                // Coincident stop causes merge into a single quit pulse.
                if (run_stop) begin
                    quit_d  = 1'b1;
                    state_d = ST_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYC);
                    if (brk_match) begin
                        brk_hit_d = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // BREAK is legal in every accepting state; the match above uses the old value.
        if (cmd_acc && (cmd_code == CMD_BREAK)) begin
            brk_pc_d = {cmd_data[31:2], 2'b00};
            brk_en_d = cmd_data[0];
        end
    end

    assign ready_d = (state_d != ST_DRAIN);

    assign cmd_ready   = ready_q;
    assign cmd_err     = err_q;
    assign cpu_start   = cpu_start_q;
    assign quit_cmd    = quit_q;
    assign start_pc    = start_pc_q;
    assign run_state   = state_q;
    assign brk_hit     = brk_hit_q;
    assign step_remain = step_q;

endmodule
